// File: rtl/canvas_writer.sv
// Pixel-write sequencer for a 160x120 canvas: 2x2 brush strokes from the mouse
// and a full-screen clear sweep on each rising edge of erase.
module canvas_writer #(
  parameter logic [14:0] CLEAR_COLOUR = 15'h7FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw,
  input  logic        erase,
  input  logic [14:0] color,
  input  logic [7:0]  mouse_x,
  input  logic [6:0]  mouse_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [14:0] vga_colour,
  output logic        plot,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BRUSH, CLEAR} state_t;

  state_t      r_state, w_state;
  logic [1:0]  r_idx, w_idx;
  logic [7:0]  r_bx, w_bx, r_last_x, w_last_x, r_vga_x, w_vga_x;
  logic [6:0]  r_by, w_by, r_last_y, w_last_y, r_vga_y, w_vga_y;
  logic [14:0] r_bcol, w_bcol, r_last_col, w_last_col, r_vga_colour, w_vga_colour;
  logic        r_last_valid, w_last_valid;
  logic        r_erase_q;
  logic        r_plot, w_plot, r_busy, w_busy;

  logic        w_erase_evt, w_dup, w_in_range;
  logic [1:0]  w_nidx;
  logic [7:0]  w_px;
  logic [6:0]  w_py;

  assign w_erase_evt = erase & ~r_erase_q;
  assign w_in_range  = (mouse_x <= 8'd159) && (mouse_y <= 7'd119);
  assign w_dup       = r_last_valid && (mouse_x == r_last_x) && (mouse_y == r_last_y)
                       && (color == r_last_col);
  // Brush pixel order: bit0 of the index steps x, bit1 steps y.
  assign w_nidx      = r_idx + 2'd1;
  assign w_px        = r_bx + {7'd0, w_nidx[0]};
  assign w_py        = r_by + {6'd0, w_nidx[1]};

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_bx         = r_bx;
    w_by         = r_by;
    w_bcol       = r_bcol;
    w_last_x     = r_last_x;
    w_last_y     = r_last_y;
    w_last_col   = r_last_col;
    w_last_valid = r_last_valid;
    w_vga_x      = r_vga_x;
    w_vga_y      = r_vga_y;
    w_vga_colour = r_vga_colour;
    w_plot       = 1'b0;
    w_busy       = 1'b0;
    if (w_erase_evt) begin
      w_state      = CLEAR;
      w_vga_x      = 8'd0;
      w_vga_y      = 7'd0;
      w_vga_colour = CLEAR_COLOUR;
      w_plot       = 1'b1;
      w_busy       = 1'b1;
      w_last_valid = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (draw && !erase && w_in_range && !w_dup) begin
            w_state      = BRUSH;
            w_idx        = 2'd0;
            w_bx         = mouse_x;
            w_by         = mouse_y;
            w_bcol       = color;
            w_vga_x      = mouse_x;
            w_vga_y      = mouse_y;
            w_vga_colour = color;
            w_plot       = 1'b1;
            w_busy       = 1'b1;
          end
        end
        BRUSH: begin
          if (r_idx == 2'd3) begin
            w_state      = IDLE;
            w_last_x     = r_bx;
            w_last_y     = r_by;
            w_last_col   = r_bcol;
            w_last_valid = 1'b1;
          end else begin
            w_idx        = w_nidx;
            w_vga_x      = w_px;
            w_vga_y      = w_py;
            w_vga_colour = r_bcol;
            w_plot       = (w_px <= 8'd159) && (w_py <= 7'd119);
            w_busy       = 1'b1;
          end
        end
        CLEAR: begin
          if ((r_vga_x == 8'd159) && (r_vga_y == 7'd119)) begin
            w_state = IDLE;
          end else begin
            if (r_vga_x == 8'd159) begin
              w_vga_x = 8'd0;
              w_vga_y = r_vga_y + 7'd1;
            end else begin
              w_vga_x = r_vga_x + 8'd1;
            end
            w_vga_colour = CLEAR_COLOUR;
            w_plot       = 1'b1;
            w_busy       = 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  // erase_q resets high so an erase already asserted at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      r_bx         <= 8'd0;
      r_by         <= 7'd0;
      r_bcol       <= 15'd0;
      r_last_x     <= 8'd0;
      r_last_y     <= 7'd0;
      r_last_col   <= 15'd0;
      r_last_valid <= 1'b0;
      r_erase_q    <= 1'b1;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= 15'd0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_bx         <= w_bx;
      r_by         <= w_by;
      r_bcol       <= w_bcol;
      r_last_x     <= w_last_x;
      r_last_y     <= w_last_y;
      r_last_col   <= w_last_col;
      r_last_valid <= w_last_valid;
      r_erase_q    <= erase;
      r_vga_x      <= w_vga_x;
      r_vga_y      <= w_vga_y;
      r_vga_colour <= w_vga_colour;
      r_plot       <= w_plot;
      r_busy       <= w_busy;
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;

endmodule

// File: tb/tb_canvas_writer.sv
// Directed bench for canvas_writer: expected pixels are queued as stimulus is
// applied and checked in order by a monitor whenever plot is high.
module tb_canvas_writer;

  logic        clk, reset, draw, erase;
  logic [14:0] color;
  logic [7:0]  mouse_x;
  logic [6:0]  mouse_y;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [14:0] vga_colour;
  logic        plot, busy;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] c;
  } pix_t;

  pix_t q[$];
  int total = 0;
  int bad = 0;

  canvas_writer #(.CLEAR_COLOUR(15'h7FFF)) dut (
    .clk(clk), .reset(reset), .draw(draw), .erase(erase), .color(color),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every plotted pixel must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_plot got=(%0d,%0d,%h) want=no plot", vga_x, vga_y, vga_colour);
      end else begin
        pix_t e;
        e = q.pop_front();
        assert ((vga_x === e.x) && (vga_y === e.y) && (vga_colour === e.c)) else begin
          bad++;
          $error("FAIL pixel got=(%0d,%0d,%h) want=(%0d,%0d,%h)",
                 vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic e, input logic [7:0] x,
                               input logic [6:0] y, input logic [14:0] c);
    draw = d; erase = e; mouse_x = x; mouse_y = y; color = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushPix(input int x, input int y, input int c);
    pix_t p;
    p.x = x[7:0]; p.y = y[6:0]; p.c = c[14:0];
    q.push_back(p);
  endtask

  task automatic pushClear(input int n);
    for (int k = 0; k < n; k++) pushPix(k % 160, k / 160, 15'h7FFF);
  endtask

  task automatic pushBrush(input int x, input int y, input int c);
    for (int i = 0; i < 4; i++)
      if ((x + (i & 1)) <= 159 && (y + (i >> 1)) <= 119)
        pushPix(x + (i & 1), y + (i >> 1), c);
  endtask

  initial begin
    int cnt;
    int plots;
    bit done;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 7'd0, 15'd0);
    repeat (3) tick();
    checkOutput("reset_plot", plot, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_x", vga_x, 8'd0);
    checkOutput("reset_y", vga_y, 7'd0);
    checkOutput("reset_colour", vga_colour, 15'd0);

    // First clear: erase low one cycle after release, then high.
    reset = 1'b1;
    tick();
    pushClear(19200);
    erase = 1'b1;
    cnt = 0;
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      tick();
      if (plot === 1'b1) cnt++;
      else if (cnt > 0) done = 1;
    end
    checkOutput("clear_len", cnt, 19200);
    checkOutput("clear_busy_drop", busy, 1'b0);
    plots = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (plot === 1'b1) plots++;
    end
    checkOutput("no_reclear_held", plots, 0);
    erase = 1'b0;
    tick();

    // Brush at (10,20).
    pushBrush(10, 20, 15'h001F);
    applyStimulus(1'b1, 1'b0, 8'd10, 7'd20, 15'h001F);
    tick();
    draw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("brush_plot", plot, 1'b1);
      checkOutput("brush_busy", busy, 1'b1);
      tick();
    end
    checkOutput("brush_end_plot", plot, 1'b0);
    checkOutput("brush_end_busy", busy, 1'b0);
    tick();

    // Corner brush: only (159,119) is on canvas.
    pushBrush(159, 119, 15'h1234);
    applyStimulus(1'b1, 1'b0, 8'd159, 7'd119, 15'h1234);
    tick();
    draw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("corner_plot", plot, (i == 0) ? 1'b1 : 1'b0);
      checkOutput("corner_busy", busy, 1'b1);
      tick();
    end
    checkOutput("corner_end_busy", busy, 1'b0);

    // Held draw at a fixed spot brushes once; moving re-brushes.
    pushBrush(50, 50, 15'h0ABC);
    applyStimulus(1'b1, 1'b0, 8'd50, 7'd50, 15'h0ABC);
    plots = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (plot === 1'b1) plots++;
    end
    checkOutput("dedupe_plots", plots, 4);
    pushBrush(51, 50, 15'h0ABC);
    mouse_x = 8'd51;
    plots = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (plot === 1'b1) plots++;
    end
    checkOutput("moved_plots", plots, 4);
    draw = 1'b0;
    tick();

    // Erase edge in the 2nd brush cycle aborts the brush.
    pushPix(70, 30, 15'h0111);
    pushPix(71, 30, 15'h0111);
    pushClear(19200);
    applyStimulus(1'b1, 1'b0, 8'd70, 7'd30, 15'h0111);
    tick();
    draw = 1'b0;
    tick();
    erase = 1'b1;
    tick();
    checkOutput("abort_plot", plot, 1'b1);
    checkOutput("abort_x", vga_x, 8'd0);
    checkOutput("abort_y", vga_y, 7'd0);
    checkOutput("abort_colour", vga_colour, 15'h7FFF);
    erase = 1'b0;
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      tick();
      if (busy === 1'b0) done = 1;
    end
    checkOutput("abort_clear_done", done, 1'b1);
    tick();

    // Reset in the middle of a clear, at pixel 5000.
    pushClear(5000);
    erase = 1'b1;
    tick();
    repeat (5000) tick();
    reset = 1'b0;
    #1;
    checkOutput("midreset_plot", plot, 1'b0);
    checkOutput("midreset_busy", busy, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    plots = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (plot === 1'b1) plots++;
    end
    checkOutput("no_clear_after_reset", plots, 0);
    erase = 1'b0;
    tick();

    // Out-of-range coordinates are ignored.
    applyStimulus(1'b1, 1'b0, 8'd160, 7'd5, 15'h0222);
    plots = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (plot === 1'b1 || busy === 1'b1) plots++;
    end
    checkOutput("oor_x", plots, 0);
    applyStimulus(1'b1, 1'b0, 8'd5, 7'd120, 15'h0222);
    plots = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (plot === 1'b1 || busy === 1'b1) plots++;
    end
    checkOutput("oor_y", plots, 0);
    draw = 1'b0;
    repeat (2) tick();
    checkOutput("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canvas_writer.md
CANVAS_WRITER -- requirements
Module: canvas_writer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port: draw  input  1  mouse-draw level from the io control stage.
REQ-004 SHALL have port: erase  input  1  canvas-erase level from the io control stage.
REQ-005 SHALL have port: color  input  15  brush colour from the io control stage.
REQ-006 SHALL have port: mouse_x  input  8  cursor column, legal 0..159.
REQ-007 SHALL have port: mouse_y  input  7  cursor row, legal 0..119.
REQ-008 SHALL have port: vga_x  output  8  pixel column to write.
REQ-009 SHALL have port: vga_y  output  7  pixel row to write.
REQ-010 SHALL have port: vga_colour  output  15  pixel colour to write.
REQ-011 SHALL have port: plot  output  1  write strobe; pixel written when 1 on a rising clk edge.
REQ-012 SHALL have port: busy  output  1  1 while in BRUSH or CLEAR.
REQ-013 SHALL have parameter: CLEAR_COLOUR, default 15'h7FFF, colour written by a clear sweep.

Function
REQ-014 SHALL implement FSM states IDLE, BRUSH, CLEAR; all outputs registered.
REQ-015 SHALL register erase each cycle (erase_q) and treat erase=1 with erase_q=0 as an erase event.
REQ-016 SHALL, on an erase event in any state, enter CLEAR next cycle, abandoning any BRUSH in progress; priority erase event > draw.
REQ-017 SHALL in CLEAR emit plot=1 every cycle, row-major: x 0..159 within a row, y 0..119, vga_colour=CLEAR_COLOUR, starting at (0,0).
REQ-018 SHALL complete CLEAR after exactly 19200 plot cycles, last pixel (159,119), then go to IDLE.
REQ-019 SHALL NOT restart CLEAR while erase stays high after completion; a new clear needs erase low for at least one cycle, then high.
REQ-020 SHALL, in IDLE with draw=1, erase=0, mouse_x<=159 and mouse_y<=119, latch mouse_x, mouse_y, color and enter BRUSH.
REQ-021 SHALL ignore draw when mouse_x>159 or mouse_y>119 (stay IDLE, plot=0).
REQ-022 SHALL skip the brush (stay IDLE) if latched coordinates and colour equal those of the last completed brush and no CLEAR has occurred since.
REQ-023 SHALL in BRUSH emit 4 consecutive cycles at (x,y), (x+1,y), (x,y+1), (x+1,y+1) with vga_colour=latched colour; first plot one cycle after the latch edge.
REQ-024 SHALL drive plot=0 in the BRUSH cycle of any pixel with x+1>159 or y+1>119 (no wrap); vga_x/vga_y in that cycle are don't-care.
REQ-025 SHALL return to IDLE after the 4th BRUSH cycle and may re-latch on the following cycle if draw is still 1.
REQ-026 SHALL ignore changes on mouse_x, mouse_y, color and draw during BRUSH and CLEAR.
REQ-027 SHALL hold plot=0 and busy=0 in IDLE.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, erase_q=1, last-brush record invalid.
REQ-029 SHALL, with erase_q=1 at reset release, not clear if erase is already high; the first clear needs a fresh erase rising edge.
REQ-030 SHALL abort BRUSH or CLEAR immediately on reset assertion mid-operation, with no further plot.

Verification
REQ-031 Reset release, erase low 1 cycle then high -> plot high 19200 consecutive cycles, first (0,0), last (159,119), colour 7FFF, busy drops the next cycle.
REQ-032 draw=1, (10,20), color=001F -> plots (10,20),(11,20),(10,21),(11,21) on cycles 1-4 after latch, colour 001F, then IDLE.
REQ-033 draw=1 at (159,119) -> exactly one plot, (159,119); other 3 brush cycles plot=0.
REQ-034 draw held at fixed (50,50), same colour -> one brush only; move to (51,50) -> new brush.
REQ-035 erase rising edge during 2nd BRUSH cycle -> next cycle CLEAR at (0,0); no further brush pixels.
REQ-036 reset=0 mid-CLEAR at pixel 5000 -> plot=0 and busy=0 immediately; after release with erase still high -> no clear.
